// File: rtl/fp8_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fp8_seq_pkg
//  Description : Shared types and constants for the FP8 multiplier
//                sequencer. Holds the controller state encoding, the FP8
//                word width, the E4M3 quiet-NaN code written on timeout, and
//                the result-FIFO entry layout.
//  Revision    : 1.0 - initial release
// ============================================================================
package fp8_seq_pkg;

    // Width of one FP8 operand / result byte.
    localparam int FP8_W = 8;

    // E4M3 NaN pattern substituted for a result that never arrived.
    localparam logic [FP8_W-1:0] FP8_QNAN = 8'h7F;

    // Controller states: two operand-collection states, the start-issue
    // state (which can stall on a full result FIFO) and the wait-for-done
    // state.
    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        ISSUE  = 2'd2,
        WAIT   = 2'd3
    } seq_state_t;

    // One result FIFO entry: error flag above the 8-bit product.
    typedef struct packed {
        logic             err;
        logic [FP8_W-1:0] data;
    } result_t;

endpackage : fp8_seq_pkg
`default_nettype wire

// File: rtl/fp8_result_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : fp8_result_fifo
//  Description : Small synchronous FIFO of result entries. The head entry is
//                read straight from registered storage, so it is valid
//                whenever the FIFO is non-empty and simply holds stale data
//                when empty. Simultaneous push and pop leave the occupancy
//                unchanged and keep entries in order.
//  Ports       : clk, rst_n       - clock, asynchronous active-low reset
//                push, push_data  - write request and entry
//                pop              - read request (ignored when empty)
//                head             - entry at the read pointer
//                count            - number of stored entries (0..DEPTH)
//                full, empty      - occupancy flags
//  Revision    : 1.0 - initial release
// ============================================================================
module fp8_result_fifo
    import fp8_seq_pkg::*;
#(
    parameter int DEPTH = 2     // entries, power of two, >= 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  result_t                  push_data,
    input  logic                     pop,
    output result_t                  head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int            AW      = $clog2(DEPTH);
    localparam logic [AW:0]   DEPTH_C = (AW + 1)'(DEPTH);

    result_t        r_mem [DEPTH];
    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  r_rd_ptr;
    logic [AW:0]    r_count;

    logic           w_push;
    logic           w_pop;

    assign empty  = (r_count == '0);
    assign full   = (r_count == DEPTH_C);

    // A pop from an empty FIFO is dropped; a push into a full FIFO is only
    // taken when the same cycle also frees a slot.
    assign w_pop  = pop && !empty;
    assign w_push = push && (!full || w_pop);

    // Pointers are exactly AW bits wide, so for a power-of-two depth they
    // wrap modulo DEPTH without extra logic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= push_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign head  = r_mem[r_rd_ptr];
    assign count = r_count;

endmodule : fp8_result_fifo
`default_nettype wire

// File: rtl/fp8_mul_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : fp8_mul_seq_ctrl
//  Description : Sequencer between the byte-wide pin interface and the FP8
//                multiplier core. Collects operand A then operand B on a
//                valid/ready byte input, issues a single start pulse, waits
//                for done (bounded by TIMEOUT cycles) and queues the result,
//                or a NaN error entry on timeout, in a result FIFO drained
//                over a valid/ready output.
//  Ports       : clk, rst_n                 - clock, async active-low reset
//                in_data/in_valid/in_ready  - operand byte stream (A, B)
//                mul_a, mul_b, mul_start    - operands and start to the core
//                mul_done, mul_result       - core completion and product
//                out_data/out_err/out_valid/out_ready - result stream
//                busy                       - operation in flight or results
//                                             still queued
//                op_count                   - completed operations, wrapping
//  Revision    : 1.0 - initial release
// ============================================================================
module fp8_mul_seq_ctrl
    import fp8_seq_pkg::*;
#(
    parameter int FIFO_DEPTH = 2,   // result FIFO entries, power of two, >= 2
    parameter int TIMEOUT    = 15   // WAIT cycles before forced error, 1..255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [FP8_W-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [FP8_W-1:0] mul_a,
    output logic [FP8_W-1:0] mul_b,
    output logic             mul_start,
    input  logic             mul_done,
    input  logic [FP8_W-1:0] mul_result,
    output logic [FP8_W-1:0] out_data,
    output logic             out_err,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic [7:0]       op_count
);

    localparam int         CW         = $clog2(FIFO_DEPTH) + 1;
    localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

    seq_state_t        r_state;
    logic [FP8_W-1:0]  r_mul_a;
    logic [FP8_W-1:0]  r_mul_b;
    logic              r_mul_start;
    logic [7:0]        r_timer;
    logic [7:0]        r_op_count;

    logic              w_accept;
    logic              w_timeout;
    logic              w_push;
    logic              w_pop;
    logic              w_space;
    result_t           w_push_data;
    result_t           w_head;
    logic [CW-1:0]     w_fifo_count;
    logic              w_fifo_full;
    logic              w_fifo_empty;

    // ------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------
    assign in_ready  = (r_state == LOAD_A) || (r_state == LOAD_B);
    assign w_accept  = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

    // The last legal WAIT cycle is the one where the timer reads
    // TIMEOUT-1, giving exactly TIMEOUT WAIT cycles before the forced
    // error entry.
    assign w_timeout = (r_timer == TIMER_LAST);

    // Only WAIT produces results; done wins over a coincident timeout.
    assign w_push    = (r_state == WAIT) && (mul_done || w_timeout);

    always_comb begin
        w_push_data.err  = 1'b0;
        w_push_data.data = mul_result;
        if (!mul_done) begin
            w_push_data.err  = 1'b1;
            w_push_data.data = FP8_QNAN;
        end
    end

    // Free-slot prediction for the next cycle. Pushes only happen in WAIT,
    // so while collecting B or stalling in ISSUE the occupancy next cycle
    // is the current one minus any pop now. Registering the start from
    // this prediction lets mul_start be high in the same cycle the state
    // sits in ISSUE, and that pulse is what moves the FSM on to WAIT.
    assign w_space   = !w_fifo_full || w_pop;

    // ------------------------------------------------------------------
    // Controller FSM, operand registers, timer and op counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= LOAD_A;
            r_mul_a     <= '0;
            r_mul_b     <= '0;
            r_mul_start <= 1'b0;
            r_timer     <= '0;
            r_op_count  <= '0;
        end else begin
            r_mul_start <= 1'b0;
            case (r_state)
                LOAD_A: begin
                    if (w_accept) begin
                        r_mul_a <= in_data;
                        r_state <= LOAD_B;
                    end
                end
                LOAD_B: begin
                    if (w_accept) begin
                        r_mul_b     <= in_data;
                        r_state     <= ISSUE;
                        r_mul_start <= w_space;
                    end
                end
                ISSUE: begin
                    if (r_mul_start) begin
                        r_timer <= '0;
                        r_state <= WAIT;
                    end else begin
                        r_mul_start <= w_space;
                    end
                end
                WAIT: begin
                    r_timer <= r_timer + 8'd1;
                    if (w_push) begin
                        r_op_count <= r_op_count + 8'd1;
                        r_state    <= LOAD_A;
                    end
                end
                default: r_state <= LOAD_A;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Result FIFO
    // ------------------------------------------------------------------
    fp8_result_fifo #(
        .DEPTH     (FIFO_DEPTH)
    ) u_result_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_push),
        .push_data (w_push_data),
        .pop       (w_pop),
        .head      (w_head),
        .count     (w_fifo_count),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty)
    );

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign mul_a     = r_mul_a;
    assign mul_b     = r_mul_b;
    assign mul_start = r_mul_start;
    assign out_data  = w_head.data;
    assign out_err   = w_head.err;
    assign out_valid = (w_fifo_count != '0);
    assign busy      = (r_state != LOAD_A) || !w_fifo_empty;
    assign op_count  = r_op_count;

endmodule : fp8_mul_seq_ctrl
`default_nettype wire

// File: tb/tb_fp8_mul_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fp8_mul_seq_ctrl
//  Description : Self-checking bench for fp8_mul_seq_ctrl. A behavioural
//                multiplier core answers each start after a planned latency
//                (or never), an output consumer drains results, and an
//                expected-result queue derived from the latency rules is
//                compared against every popped entry.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fp8_mul_seq_ctrl;

    localparam int TIMEOUT = 15;
    localparam int DEPTH   = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] mul_a;
    logic [7:0] mul_b;
    logic       mul_start;
    logic       mul_done;
    logic [7:0] mul_result;
    logic [7:0] out_data;
    logic       out_err;
    logic       out_valid;
    logic       out_ready;
    logic       busy;
    logic [7:0] op_count;

    // Core-model and directed-injection drivers of the core outputs.
    logic       core_done;
    logic [7:0] core_res;
    logic       inj_done;
    logic [7:0] inj_res;

    assign mul_done   = core_done | inj_done;
    assign mul_result = inj_done ? inj_res : core_res;

    fp8_mul_seq_ctrl #(
        .FIFO_DEPTH (DEPTH),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_start  (mul_start),
        .mul_done   (mul_done),
        .mul_result (mul_result),
        .out_data   (out_data),
        .out_err    (out_err),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .op_count   (op_count)
    );

    always #5 clk = ~clk;

    // Operation plan, indexed by start number.
    int         lat_plan [1024];
    logic [7:0] res_plan [1024];
    logic [7:0] a_plan   [1024];
    logic [7:0] b_plan   [1024];
    int         planned;

    logic [8:0] exp_q [$];      // {err, data} expected in pop order
    int         cyc;
    int         start_cnt;
    int         last_start;
    int         cd;             // cycles until the core model answers
    logic [7:0] pend_res;
    logic       prev_start;
    int         rdy_mode;       // 0: held low except pulses, 1: high, 2: random
    int         pulse;
    int         acc_cyc;
    int         acc_a;
    int         n_cmp;
    int         n_fail;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: advance, then run the core model and the consumer at a
    // point safely after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        core_done = 1'b0;
        if (cd > 0) begin
            cd--;
            if (cd == 0) begin
                core_done = 1'b1;
                core_res  = pend_res;
            end
        end
        if (mul_start) begin
            check("start_pulse_width", {31'b0, prev_start}, 0);
            check("mul_a_at_start", {24'b0, mul_a}, {24'b0, a_plan[start_cnt]});
            check("mul_b_at_start", {24'b0, mul_b}, {24'b0, b_plan[start_cnt]});
            cd       = lat_plan[start_cnt];
            pend_res = res_plan[start_cnt];
            if (cd >= 1 && cd <= TIMEOUT) exp_q.push_back({1'b0, pend_res});
            else                          exp_q.push_back({1'b1, 8'h7F});
            last_start = cyc;
            start_cnt++;
        end
        prev_start = mul_start;
        case (rdy_mode)
            1:       out_ready = 1'b1;
            2:       out_ready = 1'($urandom_range(0, 1));
            default: begin
                out_ready = (pulse > 0);
                if (pulse > 0) pulse--;
            end
        endcase
        if (out_valid && out_ready) begin
            n_cmp++;
            assert (exp_q.size() != 0) else begin
                n_fail++;
                $error("FAIL pop_unexpected: observed %0h expected none", {out_err, out_data});
            end
            if (exp_q.size() != 0) begin
                check("pop_result", {23'b0, out_err, out_data}, {23'b0, exp_q[0]});
                void'(exp_q.pop_front());
            end
        end
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) tick();
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n        = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && n < 300) begin
            tick();
            n++;
        end
        check("send_in_ready", {31'b0, in_ready}, 1);
        acc_cyc = cyc;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] r, input int lat);
        a_plan[planned]   = a;
        b_plan[planned]   = b;
        res_plan[planned] = r;
        lat_plan[planned] = lat;
        planned++;
        send_byte(a);
        acc_a = acc_cyc;
        send_byte(b);
    endtask

    task automatic wait_start(input int prev);
        int n;
        n = 0;
        while (start_cnt <= prev && n < 300) begin
            tick();
            n++;
        end
        check("start_seen", {31'b0, (start_cnt > prev)}, 1);
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            tick();
            n++;
        end
        check("idle", {31'b0, busy}, 0);
    endtask

    initial begin
        int prev;
        int s;
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0;
        inj_done = 1'b0; inj_res = '0; core_done = 1'b0; core_res = '0;
        out_ready = 1'b0; rdy_mode = 0; pulse = 0; planned = 0;
        cyc = 0; start_cnt = 0; last_start = 0; cd = 0; pend_res = '0;
        prev_start = 1'b0; acc_cyc = 0; acc_a = 0; n_cmp = 0; n_fail = 0;

        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // Reset state
        check("rst_in_ready",  {31'b0, in_ready}, 1);
        check("rst_out_valid", {31'b0, out_valid}, 0);
        check("rst_out_data",  {24'b0, out_data}, 0);
        check("rst_out_err",   {31'b0, out_err}, 0);
        check("rst_op_count",  {24'b0, op_count}, 0);
        check("rst_busy",      {31'b0, busy}, 0);
        check("rst_mul_start", {31'b0, mul_start}, 0);
        check("rst_mul_a",     {24'b0, mul_a}, 0);
        check("rst_mul_b",     {24'b0, mul_b}, 0);

        // 1.0 x 2.0, core answers three cycles after start
        prev = start_cnt;
        do_op(8'h38, 8'h40, 8'h40, 3);
        wait_start(prev);
        s = last_start;
        check("start_latency", 32'(s - acc_a), 2);
        wait_until(s + 3);
        check("lat_not_yet_valid", {31'b0, out_valid}, 0);
        check("lat_busy_wait", {31'b0, busy}, 1);
        tick();
        check("op1_valid",    {31'b0, out_valid}, 1);
        check("op1_data",     {24'b0, out_data}, 32'h40);
        check("op1_err",      {31'b0, out_err}, 0);
        check("op1_op_count", {24'b0, op_count}, 1);
        check("op1_mul_a",    {24'b0, mul_a}, 32'h38);
        check("op1_mul_b",    {24'b0, mul_b}, 32'h40);
        check("op1_one_start", 32'(start_cnt - prev), 1);
        rdy_mode = 1;
        wait_idle(100);

        // Core never answers: timeout entry after TIMEOUT WAIT cycles
        rdy_mode = 0;
        prev = start_cnt;
        do_op(8'h11, 8'h22, 8'h00, 0);
        wait_start(prev);
        s = last_start;
        wait_until(s + TIMEOUT);
        check("to_not_yet_valid", {31'b0, out_valid}, 0);
        check("to_still_wait",    {31'b0, in_ready}, 0);
        tick();
        check("to_valid",    {31'b0, out_valid}, 1);
        check("to_data",     {24'b0, out_data}, 32'h7F);
        check("to_err",      {31'b0, out_err}, 1);
        check("to_in_ready", {31'b0, in_ready}, 1);
        check("to_op_count", {24'b0, op_count}, 2);
        rdy_mode = 1;
        wait_idle(100);

        // Full FIFO: third operation stalls in ISSUE until a slot frees
        rdy_mode = 0;
        prev = start_cnt;
        do_op(8'h3C, 8'h44, 8'h51, 2);
        do_op(8'h30, 8'h48, 8'h52, 2);
        do_op(8'h28, 8'h4C, 8'h53, 2);
        repeat (3) begin
            tick();
            check("stall_mul_start", {31'b0, mul_start}, 0);
            check("stall_in_ready",  {31'b0, in_ready}, 0);
        end
        check("stall_starts",    32'(start_cnt - prev), 2);
        check("stall_out_valid", {31'b0, out_valid}, 1);
        pulse = 1;
        wait_start(prev + 2);
        check("stall_released", 32'(start_cnt - prev), 3);
        rdy_mode = 1;
        wait_idle(100);
        check("stall_op_count", {24'b0, op_count}, 5);

        // Done on the exact timeout cycle wins, single entry
        rdy_mode = 0;
        prev = start_cnt;
        do_op(8'h50, 8'h44, 8'h48, TIMEOUT);
        wait_start(prev);
        s = last_start;
        wait_until(s + TIMEOUT + 1);
        check("tie_valid",    {31'b0, out_valid}, 1);
        check("tie_data",     {24'b0, out_data}, 32'h48);
        check("tie_err",      {31'b0, out_err}, 0);
        check("tie_op_count", {24'b0, op_count}, 6);
        wait_until(s + TIMEOUT + 5);
        pulse = 1;
        tick();
        tick();
        check("tie_single_entry", {31'b0, out_valid}, 0);
        check("tie_queue_empty",  32'(exp_q.size()), 0);

        // Reset during WAIT with one result queued
        prev = start_cnt;
        do_op(8'h40, 8'h40, 8'h48, 2);
        wait_start(prev);
        wait_until(last_start + 3);
        check("rw_queued", {31'b0, out_valid}, 1);
        prev = start_cnt;
        do_op(8'h44, 8'h38, 8'h4C, 10);
        wait_start(prev);
        s = last_start;
        wait_until(s + 3);
        rst_n = 1'b0;
        #1;
        check("rw_out_valid", {31'b0, out_valid}, 0);
        check("rw_op_count",  {24'b0, op_count}, 0);
        check("rw_busy",      {31'b0, busy}, 0);
        check("rw_in_ready",  {31'b0, in_ready}, 1);
        exp_q.delete();
        tick();
        tick();
        rst_n = 1'b1;
        wait_until(s + 13);
        check("late_done_out_valid", {31'b0, out_valid}, 0);
        check("late_done_op_count",  {24'b0, op_count}, 0);
        check("late_done_busy",      {31'b0, busy}, 0);

        // Spurious done in LOAD_A and in LOAD_B
        inj_res  = 8'h55;
        inj_done = 1'b1;
        tick();
        inj_done = 1'b0;
        tick();
        check("spur_a_out_valid", {31'b0, out_valid}, 0);
        check("spur_a_op_count",  {24'b0, op_count}, 0);
        check("spur_a_in_ready",  {31'b0, in_ready}, 1);
        rdy_mode = 1;
        a_plan[planned] = 8'h3C; b_plan[planned] = 8'h3A;
        res_plan[planned] = 8'h4A; lat_plan[planned] = 4;
        planned++;
        send_byte(8'h3C);
        inj_done = 1'b1;
        tick();
        inj_done = 1'b0;
        check("spur_b_in_ready", {31'b0, in_ready}, 1);
        send_byte(8'h3A);
        wait_idle(100);
        check("spur_b_op_count", {24'b0, op_count}, 1);

        // Randomized run to 256 completions since reset: counter wraps
        rdy_mode = 2;
        for (int i = 0; i < 255; i++) begin
            do_op(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                  8'($urandom_range(0, 255)), int'($urandom_range(0, TIMEOUT + 2)));
        end
        wait_idle(5000);
        check("wrap_op_count", {24'b0, op_count}, 0);
        check("end_queue_empty", 32'(exp_q.size()), 0);
        check("end_out_valid", {31'b0, out_valid}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_fp8_mul_seq_ctrl
`default_nettype wire

// File: doc/fp8_mul_seq_ctrl.md
Name: fp8_mul_seq_ctrl

Overview:
Sequencer that feeds the 8-bit FP multiplier core from the narrow byte-wide pin interface. It collects operand A and operand B as two bytes on a valid/ready input, then issues one start pulse to the multiplier and waits for done, with a timeout. Results go into a small result FIFO that drains over a valid/ready output. It sits between the top-level pin mapping and the multiplier core.

Parameters:
FIFO_DEPTH, 2, result FIFO entries (power of two, >=2)
TIMEOUT, 15, max WAIT cycles before forced error result (1..255)

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous, active-low
in_data  input  8  operand byte (first A, then B)
in_valid  input  1  in_data valid
in_ready  output  1  controller accepts a byte this cycle
mul_a  output  8  operand A to multiplier core
mul_b  output  8  operand B to multiplier core
mul_start  output  1  one-cycle start pulse to core
mul_done  input  1  core result valid (single-cycle)
mul_result  input  8  core product
out_data  output  8  FIFO head result
out_err  output  1  FIFO head is a timeout result
out_valid  output  1  FIFO non-empty
out_ready  input  1  consumer accepts head
busy  output  1  state != LOAD_A or FIFO non-empty
op_count  output  8  completed operations, wraps 255->0

Behaviour:
- Reset values: state LOAD_A, mul_a=mul_b=0, mul_start=0, FIFO empty (out_valid=0, out_data=0, out_err=0), op_count=0, timer=0, busy=0. in_ready=1 (decoded from state).
- in_ready = (state==LOAD_A || state==LOAD_B). Accept = in_valid && in_ready.
- LOAD_A: on accept, register mul_a<=in_data, go to LOAD_B.
- LOAD_B: on accept, register mul_b<=in_data, go to ISSUE.
- ISSUE: if FIFO count < FIFO_DEPTH, assert mul_start (registered, high exactly one cycle), clear timer, go to WAIT. Otherwise stall in ISSUE with mul_start=0. Free slot is guaranteed for the push.
- WAIT: timer increments each cycle. If mul_done=1, push {err=0, mul_result}, op_count+1, go to LOAD_A. Else if timer==TIMEOUT-1, push {err=1, 8'h7F (E4M3 NaN)}, op_count+1, go to LOAD_A. If mul_done and timeout occur in the same cycle, mul_done wins.
- mul_done outside WAIT is ignored. mul_a and mul_b hold their values until the next capture.
- Latency: A accepted in cycle n, B in n+1, mul_start high in n+2, WAIT starts at n+3. Done in cycle k gives out_valid=1 at k+1 (when the FIFO was empty).
- FIFO: pop = out_valid && out_ready. Push and pop in the same cycle: count unchanged, data order preserved. Pointers wrap modulo FIFO_DEPTH. out_data and out_err come from registered storage at the head pointer. When empty, out_data and out_err hold the last value and are don't-care.
- Back-to-back: the next A byte can be accepted in the cycle after the push.
- Reset mid-operation (any state): immediate return to reset values. FIFO is flushed. A late mul_done after reset release is ignored because the state is LOAD_A.

Decomposition:
- Package fp8_seq_pkg: state enum {LOAD_A, LOAD_B, ISSUE, WAIT}, localparam FP8_W=8, FP8_QNAN=8'h7F, result-entry struct {err, data[7:0]}.
- Sub-module fp8_result_fifo: parameterised sync FIFO (clk, rst_n, push, push_data, pop, head, count, full, empty). The controller FSM, timer and op_count stay in the top.

Test Plan:
- Reset, then bytes 0x38 (1.0), 0x40 (2.0); model returns 0x40 three cycles after start -> mul_a=0x38, mul_b=0x40, one mul_start pulse, out_data=0x40, out_err=0, op_count=1.
- Model never asserts done; TIMEOUT=15 -> after 15 WAIT cycles out_data=0x7F, out_err=1, state back to LOAD_A, in_ready=1.
- out_ready held 0, three ops issued -> two results buffered, third op stalls in ISSUE with mul_start=0 and in_ready=0. Pulse out_ready once -> third op issues and the results pop in order.
- mul_done on the exact timeout cycle with result 0x48 -> out_data=0x48, out_err=0, only one FIFO entry pushed.
- rst_n asserted during WAIT with one result queued -> out_valid=0, op_count=0. A mul_done after release pushes nothing.
- 256 completed ops with out_ready=1 -> op_count wraps to 0. A spurious mul_done in LOAD_A/LOAD_B has no effect.
